// File: rtl/aes_wrapper_ctr_cbc.sv
// Dual-mode (CTR/CBC) AES-128 encryptor over a four-block message.
// One iterative round per clock; a single round datapath is reused for all four blocks.
module aes_wrapper_ctr_cbc #(
  parameter int data_width = 512
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              cntrl,
  input  logic [127:0]                      key,
  input  logic [127:0]                      counter,
  input  logic [127:0]                      iv,
  input  logic [data_width-1:0]             data,
  output logic [(data_width/128)*132-1:0]   out,
  output logic                              done
);

  localparam int lane_w = 132;
  localparam int out_w  = (data_width / 128) * lane_w;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} fsm_t;

  fsm_t                  fsm_reg,   fsm_next;
  logic [1:0]            blk_reg,   blk_next;
  logic [3:0]            round_reg, round_next;
  logic [127:0]          state_reg, state_next;
  logic [127:0]          rkey_reg,  rkey_next;
  logic [127:0]          key_reg,   key_next;
  logic [127:0]          ctr_reg,   ctr_next;
  logic [data_width-1:0] data_reg,  data_next;
  logic                  mode_reg,  mode_next;
  logic [out_w-1:0]      out_reg,   out_next;
  logic                  done_reg,  done_next;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box computed as GF(2^8) inverse (a^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] t;
    r = 8'h01;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) r = gmul(r, t);
      t = gmul(t, t);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  // Byte k sits at bits [127-8k -: 8]; row = k%4, column = k/4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    int src;
    o = '0;
    for (int k = 0; k < 16; k++) begin
      src = (k % 4) + 4 * (((k / 4) + (k % 4)) % 4);
      o[127-8*k -: 8] = s[127-8*src -: 8];
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon_of(input logic [3:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [127:0] sb_state;
  logic [31:0]  key_sb;

  for (genvar gi = 0; gi < 16; gi++) begin : g_sub_state
    assign sb_state[8*gi +: 8] = sbox(state_reg[8*gi +: 8]);
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_sub_key
    assign key_sb[8*gi +: 8] = sbox(rkey_reg[8*gi +: 8]);
  end

  logic [127:0] sr_state, mc_state, rkey_new, round_out;
  logic [31:0]  key_t, n0, n1, n2, n3;
  logic [127:0] p_cur, x_run, x_start, cipher;

  // Next round key: SubWord(RotWord(w3)) ^ Rcon, then the running XOR chain.
  assign key_t    = {key_sb[23:0], key_sb[31:24]} ^ {rcon_of(round_reg), 24'h000000};
  assign n0       = rkey_reg[127:96] ^ key_t;
  assign n1       = rkey_reg[95:64]  ^ n0;
  assign n2       = rkey_reg[63:32]  ^ n1;
  assign n3       = rkey_reg[31:0]   ^ n2;
  assign rkey_new = {n0, n1, n2, n3};

  assign sr_state  = shift_rows(sb_state);
  assign mc_state  = mix_columns(sr_state);
  assign round_out = ((round_reg == 4'd10) ? sr_state : mc_state) ^ rkey_new;

  assign p_cur   = data_reg[128*blk_reg +: 128];
  // In CBC the state register still holds the previous block's ciphertext at whitening.
  assign x_run   = mode_reg ? (p_cur ^ state_reg) : (ctr_reg + 128'(blk_reg));
  assign x_start = cntrl ? (data[127:0] ^ iv) : counter;
  assign cipher  = mode_reg ? round_out : (round_out ^ p_cur);

  always_comb begin
    fsm_next   = fsm_reg;
    blk_next   = blk_reg;
    round_next = round_reg;
    state_next = state_reg;
    rkey_next  = rkey_reg;
    key_next   = key_reg;
    ctr_next   = ctr_reg;
    data_next  = data_reg;
    mode_next  = mode_reg;
    out_next   = out_reg;
    done_next  = done_reg;
    case (fsm_reg)
      S_IDLE, S_DONE: begin
        if (start) begin
          fsm_next   = S_RUN;
          done_next  = 1'b0;
          out_next   = '0;
          key_next   = key;
          ctr_next   = counter;
          data_next  = data;
          mode_next  = cntrl;
          blk_next   = 2'd0;
          round_next = 4'd1;
          state_next = x_start ^ key;
          rkey_next  = key;
        end
      end
      S_RUN: begin
        if (round_reg == 4'd0) begin
          state_next = x_run ^ key_reg;
          rkey_next  = key_reg;
          round_next = 4'd1;
        end else begin
          state_next = round_out;
          rkey_next  = rkey_new;
          if (round_reg == 4'd10) begin
            out_next[lane_w*blk_reg +: lane_w] = {1'b1, mode_reg, blk_reg, cipher};
            round_next = 4'd0;
            if (blk_reg == 2'd3) begin
              fsm_next  = S_DONE;
              done_next = 1'b1;
            end else begin
              blk_next = blk_reg + 2'd1;
            end
          end else begin
            round_next = round_reg + 4'd1;
          end
        end
      end
      default: fsm_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_reg   <= S_IDLE;
      blk_reg   <= '0;
      round_reg <= '0;
      state_reg <= '0;
      rkey_reg  <= '0;
      key_reg   <= '0;
      ctr_reg   <= '0;
      data_reg  <= '0;
      mode_reg  <= 1'b0;
      out_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      fsm_reg   <= fsm_next;
      blk_reg   <= blk_next;
      round_reg <= round_next;
      state_reg <= state_next;
      rkey_reg  <= rkey_next;
      key_reg   <= key_next;
      ctr_reg   <= ctr_next;
      data_reg  <= data_next;
      mode_reg  <= mode_next;
      out_reg   <= out_next;
      done_reg  <= done_next;
    end
  end

  assign out  = out_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_aes_wrapper_ctr_cbc.sv
// Scoreboard bench for aes_wrapper_ctr_cbc: driver pushes model results, monitor checks on done rise.
module tb_aes_wrapper_ctr_cbc;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         cntrl = 1'b0;
  logic [127:0] key = '0, counter = '0, iv = '0;
  logic [511:0] data = '0;
  logic [527:0] out;
  logic         done;

  aes_wrapper_ctr_cbc #(.data_width(512)) dut (
    .clk(clk), .rst(rst), .start(start), .cntrl(cntrl), .key(key),
    .counter(counter), .iv(iv), .data(data), .out(out), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [527:0] exp_out;
    int           exp_cyc;
  } exp_t;
  exp_t sb_q[$];

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] sb [256];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Table built by walking the multiplicative group with generator 3 and its inverse.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] pt);
    logic [31:0] w [44];
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [7:0]  rc, a0, a1, a2, a3;
    logic [31:0] tmp;
    logic [127:0] r;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int j = 0; j < 16; j++) begin
      tmp  = w[j/4];
      s[j] = pt[127-8*j -: 8] ^ tmp[31-8*(j%4) -: 8];
    end
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int j = 0; j < 16; j++) t[j] = sb[s[j]];
      for (int row = 0; row < 4; row++)
        for (int col = 0; col < 4; col++)
          s[row + 4*col] = t[row + 4*((col + row) % 4)];
      if (rnd < 10) begin
        for (int col = 0; col < 4; col++) begin
          a0 = s[4*col]; a1 = s[4*col+1]; a2 = s[4*col+2]; a3 = s[4*col+3];
          s[4*col]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*col+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*col+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*col+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int j = 0; j < 16; j++) begin
        tmp  = w[4*rnd + j/4];
        s[j] = s[j] ^ tmp[31-8*(j%4) -: 8];
      end
    end
    r = '0;
    for (int j = 0; j < 16; j++) r[127-8*j -: 8] = s[j];
    return r;
  endfunction

  function automatic logic [527:0] model(input logic m, input logic [127:0] k, input logic [127:0] c,
                                         input logic [127:0] v, input logic [511:0] d);
    logic [527:0] r;
    logic [127:0] prev, p, ct;
    logic [1:0]   ib;
    r    = '0;
    prev = v;
    for (int i = 0; i < 4; i++) begin
      p  = d[128*i +: 128];
      ib = i[1:0];
      if (m) begin
        ct   = aes_ref(k, p ^ prev);
        prev = ct;
      end else begin
        ct = aes_ref(k, c + 128'(i)) ^ p;
      end
      r[132*i +: 132] = {1'b1, m, ib, ct};
    end
    return r;
  endfunction

  function automatic logic [127:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin : monitor
    logic done_d;
    exp_t e;
    done_d = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !done_d) begin
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_done got done=1 with no pending run, required none");
        end else begin
          e = sb_q.pop_front();
          if (out !== e.exp_out) begin
            n_err++;
            $display("FAIL result got %h required %h", out, e.exp_out);
          end
          n_cmp++;
          if (cyc != e.exp_cyc) begin
            n_err++;
            $display("FAIL done_latency got edge %0d required edge %0d", cyc, e.exp_cyc);
          end
          $display("run checked: out=%h", out);
        end
      end
      done_d = done;
    end
  end

  task automatic run(input logic m, input logic [127:0] k, input logic [127:0] c,
                     input logic [127:0] v, input logic [511:0] d, input bit glitch);
    exp_t e;
    int t;
    @(negedge clk);
    cntrl = m; key = k; counter = c; iv = v; data = d; start = 1'b1;
    e.exp_out = model(m, k, c, v, d);
    e.exp_cyc = cyc + 1 + 43;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (done !== 1'b0 || out !== '0) begin
      n_err++;
      $display("FAIL start_clear got done=%b out=%h required done=0 out=0", done, out);
    end
    key = r128(); counter = r128(); iv = r128();
    data = {r128(), r128(), r128(), r128()}; cntrl = ~m;
    if (glitch) begin
      repeat (7) @(negedge clk);
      start = 1'b1; cntrl = m;
      @(negedge clk);
      start = 1'b0; cntrl = ~m;
      repeat (10) @(negedge clk);
      cntrl = m;
    end
    t = 0;
    while (!done && t < 80) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL done_timeout got done=0 after %0d cycles, required done=1", t);
    end
  endtask

  task automatic check_kat(input logic m, input logic [127:0] c [4]);
    logic [131:0] lane, want;
    logic [1:0]   ib;
    for (int i = 0; i < 4; i++) begin
      ib   = i[1:0];
      lane = out[132*i +: 132];
      want = {1'b1, m, ib, c[i]};
      n_cmp++;
      if (lane !== want) begin
        n_err++;
        $display("FAIL kat_lane%0d got %h required %h", i, lane, want);
      end
    end
  endtask

  logic [127:0] kat_key, kat_ctr, kat_iv, all1;
  logic [511:0] kat_data;
  logic [127:0] c_ctr [4];
  logic [127:0] c_cbc [4];

  initial begin : driver
    build_sbox();
    kat_key  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    kat_ctr  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    kat_iv   = 128'h000102030405060708090a0b0c0d0e0f;
    kat_data = {128'hf69f2445df4f9b17ad2b417be66c3710, 128'h30c81c46a35ce411e5fbc1191a0a52ef,
                128'hae2d8a571e03ac9c9eb76fac45af8e51, 128'h6bc1bee22e409f96e93d7e117393172a};
    c_ctr = '{128'h874d6191b620e3261bef6864990db6ce, 128'h9806f66b7970fdff8617187bb9fffdff,
              128'h5ae4df3edbd5d35e5b4f09020db03eab, 128'h1e031dda2fbe03d1792170a0f3009cee};
    c_cbc = '{128'h7649abac8119b246cee98e9b12e9197d, 128'h5086cb9b507219ee95db113a917678b2,
              128'h73bed6b8e3c1743b7116e69e22229516, 128'h3ff1caa1681fac09120eca307586e1a7};
    all1 = '1;

    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (out !== '0) begin n_err++; $display("FAIL reset_out got %h required 0", out); end
    n_cmp++;
    if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b required 0", done); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin n_err++; $display("FAIL idle_done got %b required 0", done); end

    run(1'b0, kat_key, kat_ctr, kat_iv, kat_data, 1'b0);
    check_kat(1'b0, c_ctr);
    run(1'b1, kat_key, kat_ctr, kat_iv, kat_data, 1'b0);
    check_kat(1'b1, c_cbc);
    run(1'b0, kat_key, kat_ctr, kat_iv, kat_data, 1'b1);
    check_kat(1'b0, c_ctr);

    run(1'b0, kat_key, all1, kat_iv, '0, 1'b0);
    n_cmp++;
    if (out[127:0] !== aes_ref(kat_key, all1)) begin
      n_err++; $display("FAIL wrap_c0 got %h required %h", out[127:0], aes_ref(kat_key, all1));
    end
    n_cmp++;
    if (out[259:132] !== aes_ref(kat_key, '0)) begin
      n_err++; $display("FAIL wrap_c1 got %h required %h", out[259:132], aes_ref(kat_key, '0));
    end

    // Abort mid-run: outputs must clear immediately, no result should ever appear.
    @(negedge clk);
    key = r128(); counter = r128(); iv = r128(); data = {r128(), r128(), r128(), r128()};
    cntrl = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    n_cmp++;
    if (out[131] !== 1'b1) begin n_err++; $display("FAIL lane0_written got %b required 1", out[131]); end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (out !== '0) begin n_err++; $display("FAIL abort_out got %h required 0", out); end
    n_cmp++;
    if (done !== 1'b0) begin n_err++; $display("FAIL abort_done got %b required 0", done); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int n = 0; n < 10; n++)
      run(1'($urandom_range(0, 1)), r128(), r128(), r128(),
          {r128(), r128(), r128(), r128()}, 1'($urandom_range(0, 1)));

    repeat (3) @(negedge clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++; $display("FAIL pending_results got %0d required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
